// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the F stage.
//   fetch_state_e : request/response FSM states.
//   RESET_PC      : first fetch address after reset.
//   NOP_WORD      : instruction word placed in IF/ID for bubbles and reset.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/fetch_if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, rst_n        : clock, asynchronous active-low reset
//   load              : capture load_instr/load_pc as a real instruction
//   bubble            : replace the occupant with a NOP bubble (pc kept)
//   load_instr/pc     : incoming fetched word and its address
//   instr, pc, valid  : register contents
// Neither load nor bubble means hold. load has priority over bubble.
module if_id_reg #(
  parameter logic [31:0] NOP_WORD = fetch_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP_WORD;
      pc    <= 32'h0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= load_instr;
      pc    <= load_pc;
      valid <= 1'b1;
    end else if (bubble) begin
      instr <= NOP_WORD;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: F stage of the 5-stage MIPS pipeline.
//   clk, rst_n   : clock, asynchronous active-low reset
//   npc          : next-PC from the combinational next-PC unit
//   stall_d      : D-stage occupant must hold (IF/ID frozen)
//   imem_req/addr/gnt/rvalid/rdata : instruction memory handshake,
//                  one outstanding request at most
//   pc_f         : current fetch PC
//   instr_d, pc_d, valid_d : IF/ID register contents
module fetch_stage #(
  parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter logic [31:0] NOP_WORD = fetch_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc,
  input  logic        stall_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic        valid_d
);

  import fetch_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_f_q;
  logic [31:0]  next_pc_q;
  logic         have_next_q;
  logic [31:0]  buf_q;
  logic         complete;
  logic [31:0]  fetch_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_REQ;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    complete   = 1'b0;
    fetch_word = buf_q;
    case (state_q)
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (stall_d) begin
            state_d = S_HOLD;
          end else begin
            complete   = 1'b1;
            fetch_word = imem_rdata;
            state_d    = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (!stall_d) begin
          complete = 1'b1;
          state_d  = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign imem_addr = pc_f_q;
  assign pc_f      = pc_f_q;

  // --- F stage: fetch PC, parked response, next-PC capture ---
  // npc is only meaningful while its producer sits in D. The first time D
  // advances without an F completion the value is saved, so a branch target
  // survives the branch leaving D before its delay slot returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_q      <= RESET_PC;
      next_pc_q   <= 32'h0;
      have_next_q <= 1'b0;
      buf_q       <= 32'h0;
    end else begin
      if (state_q == S_WAIT && imem_rvalid && stall_d) buf_q <= imem_rdata;
      if (complete) begin
        pc_f_q      <= have_next_q ? next_pc_q : npc;
        have_next_q <= 1'b0;
      end else if (!stall_d && !have_next_q) begin
        next_pc_q   <= npc;
        have_next_q <= 1'b1;
      end
    end
  end

  // --- F/D boundary: IF/ID register ---
  // Whenever D advances and nothing completes, a bubble takes its place.
  if_id_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (complete),
    .bubble    (!stall_d && !complete),
    .load_instr(fetch_word),
    .load_pc   (pc_f_q),
    .instr     (instr_d),
    .pc        (pc_d),
    .valid     (valid_d)
  );

endmodule
